// File: rtl/ultrasonic_scan_scheduler_pkg.sv
// Shared types and constants for the ultrasonic scan scheduler.
package ultrasonic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FIRE,
    WAIT,
    GUARD
  } scan_state_e;

  localparam int unsigned DIST_W_DEFAULT = 9;
  localparam int unsigned MAX_SENSORS    = 8;
  localparam logic [31:0] DIST_TIMEOUT   = '1;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  // Lowest set bit of a sensor mask; found=0 when the mask is empty.
  function automatic pick_t lowest_set(input logic [MAX_SENSORS-1:0] v);
    pick_t p;
    p = '0;
    for (int unsigned i = 0; i < MAX_SENSORS; i++) begin
      if (v[i] && !p.found) begin
        p.found = 1'b1;
        p.idx   = 3'(i);
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/ultrasonic_scan_scheduler_if.sv
// Handshake between the scan scheduler and the shared measurement unit.
interface ultrasonic_scan_scheduler_if #(
  parameter int unsigned DIST_W = 9
);
  logic              TriggerIn;
  logic              MeasDone;
  logic [DIST_W-1:0] MeasDist;
  logic              MeasStart;
  logic              MeasReset;
  logic              EchoOut;

  modport master (
    output MeasStart, MeasReset, EchoOut,
    input  TriggerIn, MeasDone, MeasDist
  );

  modport slave (
    input  MeasStart, MeasReset, EchoOut,
    output TriggerIn, MeasDone, MeasDist
  );
endinterface

// File: rtl/ultrasonic_scan_scheduler_timer.sv
// Loadable down-counter shared by the shot timeout and the inter-shot guard gap.
module scan_timer #(
  parameter int unsigned W = 1
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);
  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load)
      count_d = value;
    else if (count_q != '0)
      count_d = count_q - 1'b1;
  end

  always_ff @(posedge Clock) begin
    if (Reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign zero = (count_q == '0);
endmodule

// File: rtl/ultrasonic_scan_scheduler.sv
// Fires one ultrasonic transducer at a time through a shared measurement unit,
// with guard gaps, timeout aborts and a per-sensor result register.
module ultrasonic_scan_scheduler
  import ultrasonic_pkg::*;
#(
  parameter  int unsigned NUM_SENSORS    = 3,
  parameter  int unsigned DIST_W         = DIST_W_DEFAULT,
  parameter  int unsigned TIMEOUT_CYCLES = 1500000,
  parameter  int unsigned GUARD_CYCLES   = 250000,
  localparam int unsigned SEL_W   = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1,
  localparam int unsigned MAX_CYC = (TIMEOUT_CYCLES > GUARD_CYCLES) ? TIMEOUT_CYCLES : GUARD_CYCLES,
  localparam int unsigned TIMER_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic                          Start,
  input  logic                          Continuous,
  input  logic [NUM_SENSORS-1:0]        SensorEnable,
  input  logic [NUM_SENSORS-1:0]        EchoIn,
  output logic [NUM_SENSORS-1:0]        TriggerOut,
  output logic [SEL_W-1:0]              SensorSel,
  output logic [NUM_SENSORS*DIST_W-1:0] Distances,
  output logic [NUM_SENSORS-1:0]        Valid,
  output logic                          Busy,
  output logic                          ScanDone,
  ultrasonic_scan_scheduler_if.master   meas
);
  scan_state_e                   state_q, state_d;
  logic [SEL_W-1:0]              sel_q, sel_d;
  logic [NUM_SENSORS-1:0]        mask_q, mask_d;
  logic [NUM_SENSORS*DIST_W-1:0] dist_q, dist_d;
  logic [NUM_SENSORS-1:0]        valid_q, valid_d;
  logic                          busy_q, busy_d;
  logic                          start_q, start_d;
  logic                          abort_q, abort_d;
  logic                          done_q, done_d;
  logic                          tmr_load, tmr_zero;
  logic [TIMER_W-1:0]            tmr_value;
  logic [MAX_SENSORS-1:0]        above;
  pick_t                         first, nxt;
  logic                          shot_active;

  scan_timer #(.W(TIMER_W)) u_timer (
    .Clock (Clock),
    .Reset (Reset),
    .load  (tmr_load),
    .value (tmr_value),
    .zero  (tmr_zero)
  );

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    mask_d    = mask_q;
    dist_d    = dist_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    start_d   = 1'b0;
    abort_d   = 1'b0;
    done_d    = 1'b0;
    tmr_load  = 1'b0;
    tmr_value = '0;
    // Enabled sensors strictly above the current one.
    above     = {MAX_SENSORS{1'b1}} << (int'(sel_q) + 1);
    first     = lowest_set(MAX_SENSORS'(SensorEnable));
    nxt       = lowest_set(MAX_SENSORS'(mask_q) & above);

    unique case (state_q)
      IDLE: begin
        if (Start && first.found) begin
          mask_d  = SensorEnable;
          busy_d  = 1'b1;
          sel_d   = SEL_W'(first.idx);
          state_d = FIRE;
        end
      end
      FIRE: begin
        start_d        = 1'b1;
        valid_d[sel_q] = 1'b0;
        tmr_load       = 1'b1;
        tmr_value      = TIMER_W'(TIMEOUT_CYCLES - 1);
        state_d        = WAIT;
      end
      WAIT: begin
        if (meas.MeasDone || tmr_zero) begin
          tmr_load  = 1'b1;
          tmr_value = TIMER_W'(GUARD_CYCLES - 1);
          state_d   = GUARD;
          if (meas.MeasDone) begin
            dist_d[sel_q*DIST_W +: DIST_W] = meas.MeasDist;
            valid_d[sel_q]                 = 1'b1;
          end else begin
            dist_d[sel_q*DIST_W +: DIST_W] = DIST_TIMEOUT[DIST_W-1:0];
            abort_d                        = 1'b1;
          end
        end
      end
      GUARD: begin
        if (tmr_zero) begin
          if (nxt.found) begin
            sel_d   = SEL_W'(nxt.idx);
            state_d = FIRE;
          end else begin
            done_d = 1'b1;
            if (Continuous && first.found) begin
              mask_d  = SensorEnable;
              sel_d   = SEL_W'(first.idx);
              state_d = FIRE;
            end else begin
              busy_d  = 1'b0;
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      mask_q  <= '0;
      dist_q  <= '0;
      valid_q <= '0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      abort_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      mask_q  <= mask_d;
      dist_q  <= dist_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      start_q <= start_d;
      abort_q <= abort_d;
      done_q  <= done_d;
    end
  end

  assign shot_active    = (state_q == FIRE) || (state_q == WAIT);
  assign TriggerOut     = shot_active ? (NUM_SENSORS'(meas.TriggerIn) << sel_q) : '0;
  assign meas.EchoOut   = shot_active & EchoIn[sel_q];
  assign meas.MeasStart = start_q;
  assign meas.MeasReset = abort_q;
  assign SensorSel      = sel_q;
  assign Distances      = dist_q;
  assign Valid          = valid_q;
  assign Busy           = busy_q;
  assign ScanDone       = done_q;
endmodule
